// File: rtl/sipo_ctrl_pkg.sv
// Shared types and constants for the serial-in/parallel-out frame controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sipo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 4;

    // Bit counter must be able to hold WIDTH itself, hence the +1.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// Parallel word output bus of the frame controller (valid/ready).
// Latency: none (wires only).
// Backpressure: consumer holds out_ready low to keep the word parked.
interface sipo_frame_ctrl_if
    import sipo_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/sipo_shift.sv
// Parameterized shift register, new bit enters at q[0]; synchronous clear wins over shift.
// Latency: one cycle per shifted bit.
// Backpressure: none, shifts whenever en is high.
module sipo_shift
    import sipo_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    // The cast drops the old MSB, which also keeps WIDTH=1 legal.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= WIDTH'({q, din});
        end
    end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame controller: start pulse, WIDTH serial bits MSB-first (+ even parity bit when PARITY_EN is defined), double-buffered word out.
// Latency: word valid WIDTH+1 cycles after start (WIDTH+2 with PARITY_EN).
// Backpressure: a frame completing while the held word is unaccepted is dropped and sets sticky overrun.
module sipo_frame_ctrl
    import sipo_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sin,
    input  logic                  start,
    sipo_frame_ctrl_if.master     obus,
    output logic                  busy,
`ifdef PARITY_EN
    output logic                  parity_err,
`endif
    output logic                  overrun
);

    localparam int CW = cnt_width(WIDTH);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SHIFT  = SHIFT;
`ifdef PARITY_EN
    localparam logic [1:0] ST_PARITY = PARITY;
    // All WIDTH bits are registered before the parity cycle commits them.
    localparam int SR_W = WIDTH;
`else
    // The last data bit is committed straight from sin, so only WIDTH-1 bits need storage.
    localparam int SR_W = WIDTH - 1;
`endif

    logic [1:0]       state;
    logic [CW-1:0]    bit_cnt;
    logic [SR_W-1:0]  sr_q;
    logic [WIDTH-1:0] commit_word;
    logic             start_acc;
    logic             shift_en;
    logic             last_bit;
    logic             commit;

    assign start_acc = (state == ST_IDLE) && start;
    assign shift_en  = (state == ST_SHIFT);
    assign last_bit  = shift_en && (bit_cnt == CW'(WIDTH - 1));
    assign busy      = (state != ST_IDLE);

`ifdef PARITY_EN
    logic parity_bad;
    assign commit      = (state == ST_PARITY);
    assign commit_word = sr_q;
    assign parity_bad  = ^{sr_q, sin};
`else
    assign commit      = last_bit;
    assign commit_word = {sr_q, sin};
`endif

    sipo_shift #(
        .WIDTH (SR_W)
    ) u_shift (
        .clk (clk),
        .clr (rst | start_acc),
        .en  (shift_en),
        .din (sin),
        .q   (sr_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    bit_cnt <= bit_cnt + CW'(1);
                    if (last_bit) begin
`ifdef PARITY_EN
                        state <= ST_PARITY;
`else
                        state <= ST_IDLE;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output buffer: a commit against a parked word is dropped; otherwise commit and transfer may coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            obus.out_data  <= '0;
            obus.out_valid <= 1'b0;
            overrun        <= 1'b0;
`ifdef PARITY_EN
            parity_err     <= 1'b0;
`endif
        end else if (commit) begin
            if (obus.out_valid && !obus.out_ready) begin
                overrun <= 1'b1;
            end else begin
                obus.out_data  <= commit_word;
                obus.out_valid <= 1'b1;
            end
`ifdef PARITY_EN
            parity_err <= parity_bad;
`endif
        end else if (obus.out_valid && obus.out_ready) begin
            obus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl (WIDTH=4): directed frames with literal expectations, then random traffic
// checked every cycle against a frame-level reference model.
module tb_sipo_frame_ctrl;

    localparam int W = 4;
`ifdef PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sin = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic overrun;
    logic parity_err;

    always #5 clk = ~clk;

    sipo_frame_ctrl_if #(.WIDTH(W)) bus ();

    sipo_frame_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .start      (start),
        .obus       (bus),
        .busy       (busy),
`ifdef PARITY_EN
        .parity_err (parity_err),
`endif
        .overrun    (overrun)
    );

`ifndef PARITY_EN
    assign parity_err = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: frame progress as a sample count, word built arithmetically MSB-first.
    bit         m_busy;
    int         m_cnt;
    int         m_word;
    int         m_ones;
    logic       m_valid;
    logic [W-1:0] m_data;
    bit         m_ovr;
    bit         m_perr;

    always @(posedge clk) begin : model
        bit commit;
        bit xfer;
        commit = 1'b0;
        xfer   = m_valid && bus.out_ready;
        if (rst) begin
            m_busy = 0; m_cnt = 0; m_word = 0; m_ones = 0;
            m_valid = 0; m_data = '0; m_ovr = 0; m_perr = 0;
            chk_en = 1'b1;
        end else begin
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_cnt = 0; m_word = 0; m_ones = 0;
                end
            end else begin
                if (m_cnt < W) m_word = m_word * 2 + int'(sin);
                m_ones += int'(sin);
                m_cnt++;
                if (m_cnt == FL) begin
                    commit = 1'b1;
                    m_busy = 0;
                end
            end
            if (commit) begin
                if (m_valid && !bus.out_ready) begin
                    m_ovr = 1;
                end else begin
                    m_data  = W'(m_word);
                    m_valid = 1;
                end
                m_perr = (m_ones % 2) != 0;
            end else if (xfer) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model_out_data", 32'(bus.out_data), 32'(m_data));
            cmp("model_out_valid", 32'(bus.out_valid), 32'(m_valid));
            cmp("model_busy", 32'(busy), 32'(m_busy));
            cmp("model_overrun", 32'(overrun), 32'(m_ovr));
`ifdef PARITY_EN
            cmp("model_parity_err", 32'(parity_err), 32'(m_perr));
`endif
        end
    end

    task automatic set(input logic st, input logic s, input logic rdy);
        start = st;
        sin = s;
        bus.out_ready = rdy;
    endtask

    task automatic frame_bits(input logic [W-1:0] bits, input logic rdy_last);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            cmp("busy_in_frame", 32'(busy), 32'd1);
            set(1'b0, bits[W-1-i], (i == W - 1) ? rdy_last : 1'b0);
        end
    endtask

    initial begin
        logic [W-1:0] pa;
        set(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        cmp("reset_valid", 32'(bus.out_valid), 32'd0);
        cmp("reset_data", 32'(bus.out_data), 32'd0);
        cmp("reset_busy", 32'(busy), 32'd0);
        cmp("reset_overrun", 32'(overrun), 32'd0);
        cmp("reset_parity_err", 32'(parity_err), 32'd0);
        rst = 1'b0;

`ifndef PARITY_EN
        // Frame A 1,0,1,1 with a stray start in cycle 2.
        @(negedge clk); set(1'b1, 1'b0, 1'b0);
        pa = 4'b1011;
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            cmp("basic_busy", 32'(busy), 32'd1);
            set(i == 2, pa[W-i], 1'b0);
        end
        @(negedge clk);
        cmp("basic_data", 32'(bus.out_data), 32'hb);
        cmp("basic_valid", 32'(bus.out_valid), 32'd1);
        cmp("basic_busy_low", 32'(busy), 32'd0);
        set(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        cmp("hs_valid_cleared", 32'(bus.out_valid), 32'd0);
        cmp("hs_data_kept", 32'(bus.out_data), 32'hb);
        cmp("b2b_busy", 32'(busy), 32'd1);
        pa = 4'b0110;
        for (int i = 0; i < W; i++) begin
            if (i > 0) @(negedge clk);
            set(1'b0, pa[W-1-i], 1'b0);
        end
        @(negedge clk);
        cmp("b2b_data", 32'(bus.out_data), 32'h6);
        cmp("b2b_valid", 32'(bus.out_valid), 32'd1);
        set(1'b1, 1'b0, 1'b0);
        frame_bits(4'b1100, 1'b0);
        @(negedge clk);
        cmp("ovr_flag", 32'(overrun), 32'd1);
        cmp("ovr_data_kept", 32'(bus.out_data), 32'h6);
        set(1'b1, 1'b0, 1'b0);
        frame_bits(4'b1001, 1'b1);
        @(negedge clk);
        cmp("commit_xfer_data", 32'(bus.out_data), 32'h9);
        cmp("commit_xfer_valid", 32'(bus.out_valid), 32'd1);
        cmp("ovr_sticky", 32'(overrun), 32'd1);
        set(1'b1, 1'b0, 1'b0);
        @(negedge clk); set(1'b0, 1'b1, 1'b0);
        @(negedge clk); set(1'b0, 1'b1, 1'b0);
        @(negedge clk); rst = 1'b1; set(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        cmp("midrst_valid", 32'(bus.out_valid), 32'd0);
        cmp("midrst_data", 32'(bus.out_data), 32'd0);
        cmp("midrst_busy", 32'(busy), 32'd0);
        cmp("midrst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        set(1'b1, 1'b0, 1'b0);
        frame_bits(4'b0101, 1'b0);
        @(negedge clk);
        cmp("after_rst_data", 32'(bus.out_data), 32'h5);
        cmp("after_rst_valid", 32'(bus.out_valid), 32'd1);
`else
        @(negedge clk); set(1'b1, 1'b0, 1'b0);
        frame_bits(4'b1011, 1'b0);
        @(negedge clk);
        cmp("par_busy", 32'(busy), 32'd1);
        cmp("par_valid_not_yet", 32'(bus.out_valid), 32'd0);
        set(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        cmp("par_ok_valid", 32'(bus.out_valid), 32'd1);
        cmp("par_ok_data", 32'(bus.out_data), 32'hb);
        cmp("par_ok_err", 32'(parity_err), 32'd0);
        set(1'b1, 1'b0, 1'b1);
        frame_bits(4'b1011, 1'b0);
        @(negedge clk); set(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        cmp("par_bad_valid", 32'(bus.out_valid), 32'd1);
        cmp("par_bad_err", 32'(parity_err), 32'd1);
`endif

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 149) == 0);
            set($urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        rst = 1'b0;
        set(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
